// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath and its controller:
// operation codes, datapath FSM states and the default operand width.
package calc_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } calc_state_t;

endpackage

// File: rtl/calc_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH clocks.
// done is high in the cycle whose closing edge completes the product, and
// product then shows that final value so the caller can register it.
module calc_mul_seq
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;

    always_comb begin
        acc_next = acc_reg;
        if (mplier_reg[0]) begin
            acc_next = acc_reg + mcand_reg;
        end
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            mcand_reg  <= '0;
            acc_reg    <= '0;
            mplier_reg <= '0;
            count_reg  <= '0;
        end else if (start) begin
            mcand_reg  <= {{WIDTH{1'b0}}, A};
            mplier_reg <= B;
            acc_reg    <= '0;
            count_reg  <= CW'(WIDTH);
        end else if (count_reg != '0) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg - 1'b1;
        end
    end

    assign product = acc_next;
    assign done    = (count_reg == CW'(1));

endmodule

// File: rtl/calc_datapath.sv
// Calculator datapath: owns the RA/RB operand registers, starts one operation
// per rising edge of Done_in and reports a registered result with valid/busy.
module calc_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 clear_n,
    input  logic [WIDTH-1:0]     Din,
    input  logic                 WE,
    input  logic                 W1,
    input  logic [2:0]           MS,
    input  logic                 Done_in,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_valid,
    output logic                 busy,
    output logic                 ovf,
    output logic                 err
);

    logic [WIDTH-1:0]   ra_reg;
    logic [WIDTH-1:0]   rb_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2:0]         op_reg;
    calc_state_t        state_reg;
    logic               done_prev_reg;
    logic               start;

    logic [WIDTH:0]     sum_full;
    logic [2*WIDTH-1:0] diff_full;
    logic [2*WIDTH-1:0] alu_result;
    logic               alu_ovf;
    logic               alu_err;

    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Operand writes are independent of the FSM; operations use latched copies.
    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            ra_reg <= '0;
            rb_reg <= '0;
        end else if (WE) begin
            if (W1) begin
                rb_reg <= Din;
            end else begin
                ra_reg <= Din;
            end
        end
    end

    assign start     = (state_reg == IDLE) && Done_in && !done_prev_reg;
    assign mul_start = start && (MS == OP_MUL);

    calc_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .CLK    (CLK),
        .clear_n(clear_n),
        .start  (mul_start),
        .A      (ra_reg),
        .B      (rb_reg),
        .product(mul_product),
        .done   (mul_done)
    );

    // Difference computed at full result width so the sign fills the upper half.
    assign sum_full  = {1'b0, a_reg} + {1'b0, b_reg};
    assign diff_full = {{WIDTH{1'b0}}, a_reg} - {{WIDTH{1'b0}}, b_reg};

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_err    = 1'b0;
        case (op_reg)
            OP_NOP: begin
            end
            OP_ADD: begin
                alu_result = {{(WIDTH-1){1'b0}}, sum_full};
                alu_ovf    = sum_full[WIDTH];
            end
            OP_SUB: begin
                alu_result = diff_full;
                alu_ovf    = (a_reg < b_reg);
            end
            OP_MUL: begin
            end
            OP_XOR: begin
                alu_result = {{WIDTH{1'b0}}, a_reg ^ b_reg};
            end
            default: begin
                alu_err = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state_reg     <= IDLE;
            done_prev_reg <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= OP_NOP;
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            ovf           <= 1'b0;
            err           <= 1'b0;
        end else begin
            done_prev_reg <= Done_in;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg        <= ra_reg;
                        b_reg        <= rb_reg;
                        op_reg       <= MS;
                        result_valid <= 1'b0;
                        ovf          <= 1'b0;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        state_reg    <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_reg == OP_MUL) begin
                        if (mul_done) begin
                            result       <= mul_product;
                            ovf          <= 1'b0;
                            err          <= 1'b0;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                            state_reg    <= DONE;
                        end
                    end else begin
                        result       <= alu_result;
                        ovf          <= alu_ovf;
                        err          <= alu_err;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state_reg    <= DONE;
                    end
                end
                DONE: begin
                    // Held-high Done_in parks here, so it can start only one op.
                    if (!Done_in) begin
                        result_valid <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_datapath.sv
// Directed and randomized checks of calc_datapath against an arithmetic
// reference model of each operation and its expected latency.
module tb_calc_datapath;

    localparam int W = 8;

    logic          CLK = 1'b0;
    logic          clear_n = 1'b0;
    logic [W-1:0]  Din = '0;
    logic          WE = 1'b0;
    logic          W1 = 1'b0;
    logic [2:0]    MS = 3'b000;
    logic          Done_in = 1'b0;
    logic [2*W-1:0] result;
    logic          result_valid;
    logic          busy;
    logic          ovf;
    logic          err;

    int n_vec = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    calc_datapath #(.WIDTH(W)) dut (
        .CLK         (CLK),
        .clear_n     (clear_n),
        .Din         (Din),
        .WE          (WE),
        .W1          (W1),
        .MS          (MS),
        .Done_in     (Done_in),
        .result      (result),
        .result_valid(result_valid),
        .busy        (busy),
        .ovf         (ovf),
        .err         (err)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned operands.
    function automatic void ref_calc(input logic [2:0] op, input int a, input int b,
                                     output logic [15:0] r, output logic o, output logic e);
        r = 16'h0000;
        o = 1'b0;
        e = 1'b0;
        case (op)
            3'd0: ;
            3'd1: begin r = 16'(a + b); o = (a + b) > 255; end
            3'd2: begin r = 16'(a - b); o = (a < b); end
            3'd3: r = 16'(a * b);
            3'd4: r = 16'(a ^ b);
            default: e = 1'b1;
        endcase
    endfunction

    task automatic load_operands(input logic [W-1:0] a, input logic [W-1:0] b);
        WE = 1'b1; W1 = 1'b0; Din = a;
        tick();
        W1 = 1'b1; Din = b;
        tick();
        WE = 1'b0;
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit mid_write, input int hold);
        logic [15:0] er;
        logic        eo;
        logic        ee;
        int          lat;
        ref_calc(op, int'(a), int'(b), er, eo, ee);
        lat = (op == 3'b011) ? W : 1;
        load_operands(a, b);
        MS = op;
        Done_in = 1'b1;
        tick();
        check({name, "_busy_start"}, 32'(busy), 32'd1);
        check({name, "_valid_start"}, 32'(result_valid), 32'd0);
        MS = 3'($urandom_range(0, 7));
        for (int i = 1; i <= lat; i++) begin
            if (mid_write && i == 3) begin
                WE = 1'b1; W1 = 1'b0; Din = ~a;
            end else begin
                WE = 1'b0;
            end
            tick();
            if (i < lat) begin
                check({name, "_busy_exec"}, 32'(busy), 32'd1);
                check({name, "_valid_exec"}, 32'(result_valid), 32'd0);
            end
        end
        WE = 1'b0;
        check({name, "_result"}, 32'(result), 32'(er));
        check({name, "_ovf"}, 32'(ovf), 32'(eo));
        check({name, "_err"}, 32'(err), 32'(ee));
        check({name, "_valid"}, 32'(result_valid), 32'd1);
        check({name, "_busy_end"}, 32'(busy), 32'd0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check({name, "_hold_valid"}, 32'(result_valid), 32'd1);
            check({name, "_hold_busy"}, 32'(busy), 32'd0);
            check({name, "_hold_result"}, 32'(result), 32'(er));
        end
        Done_in = 1'b0;
        tick();
        check({name, "_valid_clr"}, 32'(result_valid), 32'd0);
        check({name, "_result_held"}, 32'(result), 32'(er));
        check({name, "_err_held"}, 32'(err), 32'(ee));
        $display("%s op=%0d a=0x%02h b=0x%02h result=0x%04h ovf=%0d err=%0d",
                 name, op, a, b, result, ovf, err);
    endtask

    initial begin
        #12;
        check("reset_result", 32'(result), 32'd0);
        check("reset_valid", 32'(result_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(ovf), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        tick();
        clear_n = 1'b1;
        tick();

        run_op("add", 3'b001, 8'd25, 8'd17, 1'b0, 0);
        run_op("add_ovf", 3'b001, 8'd200, 8'd100, 1'b0, 0);
        run_op("sub_borrow", 3'b010, 8'd5, 8'd9, 1'b0, 0);
        run_op("mul_max", 3'b011, 8'd255, 8'd255, 1'b1, 0);
        run_op("xor_hold", 3'b100, 8'hF0, 8'h3C, 1'b0, 20);
        run_op("invalid", 3'b110, 8'd7, 8'd3, 1'b0, 0);

        // Reset in the middle of a multiply, then release with Done_in high.
        load_operands(8'd13, 8'd11);
        MS = 3'b011;
        Done_in = 1'b1;
        tick();
        repeat (4) tick();
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        clear_n = 1'b0;
        #1;
        check("rst_mid_result", 32'(result), 32'd0);
        check("rst_mid_valid", 32'(result_valid), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ovf", 32'(ovf), 32'd0);
        check("rst_mid_err", 32'(err), 32'd0);
        MS = 3'b101;
        tick();
        clear_n = 1'b1;
        tick();
        check("rel_busy", 32'(busy), 32'd1);
        tick();
        check("rel_err", 32'(err), 32'd1);
        check("rel_valid", 32'(result_valid), 32'd1);
        check("rel_result", 32'(result), 32'd0);
        check("rel_busy_end", 32'(busy), 32'd0);
        Done_in = 1'b0;
        tick();
        $display("reset_release op=5 result=0x%04h err=%0d", result, err);

        for (int n = 0; n < 40; n++) begin
            run_op("rand", 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
                   8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", n_vec);
        $fatal(1, "simulation time limit reached");
    end

endmodule
